// File: rtl/rv32_mtimer_if.sv
// Data-bus port bundle for the machine timer: request and response signals
// between the core LSU (master) and the timer register block (slave).
interface rv32_mtimer_if;
   logic        sel;
   logic        rready;
   logic        rvalid;
   logic        wvalid;
   logic        wready;
   logic [3:0]  strb;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (
      output sel, rready, wvalid, strb, addr, wdata,
      input  rvalid, wready, rdata
   );

   modport slave (
      input  sel, rready, wvalid, strb, addr, wdata,
      output rvalid, wready, rdata
   );
endinterface

// File: rtl/rv32_mtimer.sv
// RISC-V machine timer: 64-bit mtime with prescaler, mtimecmp compare,
// level interrupt, and a coherent lo-then-hi mtime read via a shadow register.
module rv32_mtimer #(
   parameter int unsigned PRESC_WIDTH    = 16,
   parameter logic [63:0] RESET_MTIMECMP = 64'hFFFF_FFFF_FFFF_FFFF
) (
   input  logic          clk,
   input  logic          rst_n,
   rv32_mtimer_if.slave  bus,
   output logic          timer_irq
);

   typedef enum logic [2:0] {
      REG_MTIME_LO = 3'd0,
      REG_MTIME_HI = 3'd1,
      REG_CMP_LO   = 3'd2,
      REG_CMP_HI   = 3'd3,
      REG_CTRL     = 3'd4,
      REG_PRESC    = 3'd5,
      REG_RSVD6    = 3'd6,
      REG_RSVD7    = 3'd7
   } reg_off_e;

   logic [63:0]            mtime;
   logic [63:0]            mtimecmp;
   logic [31:0]            shadow;
   logic                   cnt_en;
   logic                   irq_en;
   logic [PRESC_WIDTH-1:0] presc;
   logic [PRESC_WIDTH-1:0] presc_cnt;
   logic                   resp_busy;

   reg_off_e               off;
   logic                   wr_acc;
   logic                   rd_acc;
   logic                   tick;
   logic [31:0]            rd_mux;
   logic [31:0]            wr_old;
   logic [31:0]            wr_merged;
   logic                   unused_addr_bits;

   assign off              = reg_off_e'(bus.addr[4:2]);
   assign unused_addr_bits = ^{bus.addr[31:5], bus.addr[1:0]};
   assign wr_acc           = bus.sel && bus.wvalid && !resp_busy;
   assign rd_acc           = bus.sel && bus.rready && !bus.wvalid && !resp_busy;
   assign tick             = cnt_en && (presc_cnt == presc);

   function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
      logic [31:0] res;
      res = old_v;
      for (int unsigned i = 0; i < 4; i++) begin
         if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
      end
      return res;
   endfunction

   // Read-back mux (mtime_hi returns the shadow) and byte-merged write value
   // (merged against the live register, not the shadow).
   always_comb begin
      rd_mux = '0;
      wr_old = '0;
      case (off)
         REG_MTIME_LO: begin rd_mux = mtime[31:0];     wr_old = mtime[31:0];     end
         REG_MTIME_HI: begin rd_mux = shadow;          wr_old = mtime[63:32];    end
         REG_CMP_LO:   begin rd_mux = mtimecmp[31:0];  wr_old = mtimecmp[31:0];  end
         REG_CMP_HI:   begin rd_mux = mtimecmp[63:32]; wr_old = mtimecmp[63:32]; end
         REG_CTRL: begin
            rd_mux = {30'd0, irq_en, cnt_en};
            wr_old = rd_mux;
         end
         REG_PRESC: begin
            rd_mux = 32'(presc);
            wr_old = rd_mux;
         end
         default: begin rd_mux = '0; wr_old = '0; end
      endcase
      wr_merged = lane_merge(wr_old, bus.wdata, bus.strb);
   end

   // One-cycle response pulse; resp_busy blocks acceptance during it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         resp_busy  <= 1'b0;
         bus.rvalid <= 1'b0;
         bus.wready <= 1'b0;
         bus.rdata  <= '0;
      end else begin
         resp_busy  <= wr_acc || rd_acc;
         bus.wready <= wr_acc;
         bus.rvalid <= rd_acc;
         if (rd_acc) bus.rdata <= rd_mux;
      end
   end

   // Prescale counter: wraps at presc to generate the mtime tick.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         presc_cnt <= '0;
      end else if (wr_acc && off == REG_PRESC) begin
         presc_cnt <= '0;
      end else if (cnt_en) begin
         presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
      end
   end

   // mtime counter (software write beats the tick) and the hi shadow.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mtime  <= '0;
         shadow <= '0;
      end else begin
         if (wr_acc && off == REG_MTIME_LO)      mtime[31:0]  <= wr_merged;
         else if (wr_acc && off == REG_MTIME_HI) mtime[63:32] <= wr_merged;
         else if (tick)                          mtime        <= mtime + 64'd1;
         if (rd_acc && off == REG_MTIME_LO)      shadow       <= mtime[63:32];
      end
   end

   // Software-written configuration registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mtimecmp <= RESET_MTIMECMP;
         cnt_en   <= 1'b1;
         irq_en   <= 1'b1;
         presc    <= '0;
      end else if (wr_acc) begin
         case (off)
            REG_CMP_LO: mtimecmp[31:0]   <= wr_merged;
            REG_CMP_HI: mtimecmp[63:32]  <= wr_merged;
            REG_CTRL:   {irq_en, cnt_en} <= wr_merged[1:0];
            REG_PRESC:  presc            <= wr_merged[PRESC_WIDTH-1:0];
            default:    ;
         endcase
      end
   end

   // Registered level interrupt.
   always_ff @(posedge clk) begin
      if (!rst_n) timer_irq <= 1'b0;
      else        timer_irq <= irq_en && (mtime >= mtimecmp);
   end

endmodule

// File: tb/tb_rv32_mtimer.sv
// Directed bench for rv32_mtimer. Every task starts and ends 1 ns after a
// rising edge; edge counts in comments are relative to reset release.
module tb_rv32_mtimer;
   logic clk = 1'b0;
   logic rst_n;
   logic timer_irq;
   int   checks   = 0;
   int   failures = 0;

   rv32_mtimer_if bus ();

   rv32_mtimer #(
      .PRESC_WIDTH(16),
      .RESET_MTIMECMP(64'hFFFF_FFFF_FFFF_FFFF)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus),
      .timer_irq(timer_irq)
   );

   always #5 clk = ~clk;

   localparam logic [31:0] A_LO = 32'h00, A_HI = 32'h04, A_CLO = 32'h08, A_CHI = 32'h0C;
   localparam logic [31:0] A_CTRL = 32'h10, A_PRESC = 32'h14, A_UNMAP = 32'h1C;

   task automatic bus_idle();
      bus.sel = 1'b0; bus.rready = 1'b0; bus.wvalid = 1'b0;
      bus.strb = 4'h0; bus.addr = '0; bus.wdata = '0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus_idle();
      repeat (2) begin @(posedge clk); #1; end
      rst_n = 1'b1;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic ack);
      bus.sel = 1'b1; bus.wvalid = 1'b1; bus.addr = a; bus.wdata = d; bus.strb = s;
      @(posedge clk); #1;
      ack = bus.wready;
      bus_idle();
      @(posedge clk); #1;
   endtask

   task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic v);
      bus.sel = 1'b1; bus.rready = 1'b1; bus.addr = a;
      @(posedge clk); #1;
      v = bus.rvalid;
      d = bus.rdata;
      bus_idle();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      logic [31:0] d; logic v;
      do_reset();
      checks++; if ({bus.rvalid, bus.wready, timer_irq} !== 3'b000) begin failures++; $display("FAIL reset_outs: got %b expected 000", {bus.rvalid, bus.wready, timer_irq}); end
      checks++; if (bus.rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata: got %h expected 00000000", bus.rdata); end
      do_read(A_CLO, d, v);
      checks++; if (v !== 1'b1) begin failures++; $display("FAIL reset_rvalid: got %b expected 1", v); end
      checks++; if (d !== 32'hFFFF_FFFF) begin failures++; $display("FAIL reset_cmp_lo: got %h expected ffffffff", d); end
      do_read(A_CHI, d, v);
      checks++; if (d !== 32'hFFFF_FFFF) begin failures++; $display("FAIL reset_cmp_hi: got %h expected ffffffff", d); end
      do_read(A_CTRL, d, v);
      checks++; if (d !== 32'h3) begin failures++; $display("FAIL reset_ctrl: got %h expected 00000003", d); end
      do_read(A_PRESC, d, v);
      checks++; if (d !== 32'h0) begin failures++; $display("FAIL reset_presc: got %h expected 00000000", d); end
   endtask

   task automatic test_default_count();
      logic [31:0] d; logic v;
      do_reset();
      repeat (10) begin @(posedge clk); #1; end
      // edges 1..10 ticked; read accepted at edge 11 returns 10
      do_read(A_LO, d, v);
      checks++; if (v !== 1'b1) begin failures++; $display("FAIL count_rvalid: got %b expected 1", v); end
      checks++; if (d !== 32'd10) begin failures++; $display("FAIL count_mtime_lo: got %0d expected 10", d); end
   endtask

   task automatic test_irq();
      logic ack; int e; int rise;
      do_reset();
      do_write(A_CHI, 32'h0, 4'hF, ack);   // accepted edge 1
      do_write(A_CLO, 32'd20, 4'hF, ack);  // accepted edge 3
      e = 4; rise = 0;
      // mtime reaches 20 at edge 20; registered irq rises at edge 21
      while (e < 40 && rise == 0) begin
         @(posedge clk); #1; e++;
         if (timer_irq === 1'b1) rise = e;
      end
      checks++; if (rise != 21) begin failures++; $display("FAIL irq_rise_edge: got %0d expected 21", rise); end
      bus.sel = 1'b1; bus.wvalid = 1'b1; bus.addr = A_CLO; bus.wdata = 32'hFFFF_FFFF; bus.strb = 4'hF;
      @(posedge clk); #1;
      checks++; if (timer_irq !== 1'b1) begin failures++; $display("FAIL irq_hold_at_write: got %b expected 1", timer_irq); end
      bus_idle();
      @(posedge clk); #1;
      checks++; if (timer_irq !== 1'b0) begin failures++; $display("FAIL irq_fall: got %b expected 0", timer_irq); end
   endtask

   task automatic test_coherent();
      logic [31:0] d; logic v, ack;
      do_write(A_PRESC, 32'h0, 4'hF, ack);
      do_write(A_HI, 32'h0, 4'hF, ack);
      do_write(A_LO, 32'hFFFF_FFFE, 4'hF, ack);  // W: FFFFFFFE, W+1: FFFFFFFF
      do_read(A_LO, d, v);                        // accepted W+2, carry at W+2
      checks++; if (d !== 32'hFFFF_FFFF) begin failures++; $display("FAIL coh_lo1: got %h expected ffffffff", d); end
      do_read(A_HI, d, v);
      checks++; if (d !== 32'h0) begin failures++; $display("FAIL coh_hi1: got %h expected 00000000", d); end
      do_read(A_LO, d, v);                        // accepted W+6: 1_00000003
      checks++; if (d !== 32'h3) begin failures++; $display("FAIL coh_lo2: got %h expected 00000003", d); end
      do_read(A_HI, d, v);
      checks++; if (d !== 32'h1) begin failures++; $display("FAIL coh_hi2: got %h expected 00000001", d); end
   endtask

   task automatic test_prescale();
      logic [31:0] d; logic v, ack;
      do_write(A_PRESC, 32'd2, 4'hF, ack);   // P: counter cleared
      do_write(A_LO, 32'h0, 4'hF, ack);      // P+2; ticks at P+3, P+6
      do_read(A_LO, d, v);                   // accepted P+4
      checks++; if (d !== 32'd1) begin failures++; $display("FAIL presc_r1: got %0d expected 1", d); end
      do_read(A_LO, d, v);                   // accepted P+6
      checks++; if (d !== 32'd1) begin failures++; $display("FAIL presc_r2: got %0d expected 1", d); end
      do_read(A_LO, d, v);                   // accepted P+8
      checks++; if (d !== 32'd2) begin failures++; $display("FAIL presc_r3: got %0d expected 2", d); end
   endtask

   task automatic test_freeze();
      logic [31:0] d; logic v, ack;
      do_write(A_CTRL, 32'h2, 4'h1, ack);
      do_write(A_LO, 32'd100, 4'hF, ack);
      repeat (5) begin @(posedge clk); #1; end
      do_read(A_LO, d, v);
      checks++; if (d !== 32'd100) begin failures++; $display("FAIL freeze_mtime: got %0d expected 100", d); end
      do_read(A_CTRL, d, v);
      checks++; if (d !== 32'h2) begin failures++; $display("FAIL freeze_ctrl: got %h expected 00000002", d); end
      do_write(A_CTRL, 32'h3, 4'hF, ack);
   endtask

   task automatic test_strobes_unmapped();
      logic [31:0] d; logic v, ack;
      do_write(A_PRESC, 32'h0, 4'hF, ack);
      do_write(A_PRESC, 32'hAABB_CCDD, 4'b0001, ack);
      do_read(A_PRESC, d, v);
      checks++; if (d !== 32'h0000_00DD) begin failures++; $display("FAIL strb_lane0: got %h expected 000000dd", d); end
      do_write(A_PRESC, 32'h1122_3344, 4'b0010, ack);
      do_read(32'h0000_1034, d, v);   // upper address bits ignored
      checks++; if (d !== 32'h0000_33DD) begin failures++; $display("FAIL strb_lane1: got %h expected 000033dd", d); end
      do_write(A_UNMAP, 32'hFFFF_FFFF, 4'hF, ack);
      checks++; if (ack !== 1'b1) begin failures++; $display("FAIL unmap_wready: got %b expected 1", ack); end
      do_read(A_UNMAP, d, v);
      checks++; if ({v, d} !== {1'b1, 32'h0}) begin failures++; $display("FAIL unmap_read: got v=%b d=%h expected v=1 d=00000000", v, d); end
      do_write(A_PRESC, 32'h0, 4'hF, ack);
   endtask

   task automatic test_simultaneous();
      logic [31:0] d; logic v, ack;
      do_read(A_CTRL, d, v);
      bus.sel = 1'b1; bus.rready = 1'b1; bus.wvalid = 1'b1;
      bus.addr = A_PRESC; bus.wdata = 32'd7; bus.strb = 4'hF;
      @(posedge clk); #1;
      checks++; if ({bus.wready, bus.rvalid} !== 2'b10) begin failures++; $display("FAIL sim_only_write: got wready,rvalid=%b expected 10", {bus.wready, bus.rvalid}); end
      checks++; if (bus.rdata !== 32'h3) begin failures++; $display("FAIL sim_rdata_hold: got %h expected 00000003", bus.rdata); end
      bus_idle();
      @(posedge clk); #1;
      do_read(A_PRESC, d, v);
      checks++; if (d !== 32'd7) begin failures++; $display("FAIL sim_presc: got %0d expected 7", d); end
      do_write(A_PRESC, 32'h0, 4'hF, ack);
      // tick every edge: write of 5 wins at acceptance, next edge gives 6
      do_write(A_LO, 32'd5, 4'hF, ack);
      do_read(A_LO, d, v);
      checks++; if (d !== 32'd6) begin failures++; $display("FAIL sim_tick_write: got %0d expected 6", d); end
   endtask

   task automatic test_back_to_back();
      logic [3:0] pat;
      bus.sel = 1'b1; bus.rready = 1'b1; bus.addr = A_CTRL;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         pat[i] = bus.rvalid;
      end
      bus_idle();
      @(posedge clk); #1;
      checks++; if (pat !== 4'b0101) begin failures++; $display("FAIL b2b_rvalid: got %b expected 0101", pat); end
   endtask

   task automatic test_reset_midop();
      logic [31:0] d; logic v; logic bad;
      bus.sel = 1'b1; bus.rready = 1'b1; bus.addr = A_LO;
      @(posedge clk); #1;
      rst_n = 1'b0;
      bus_idle();
      bad = 1'b0;
      repeat (2) begin @(posedge clk); #1; if (bus.rvalid !== 1'b0) bad = 1'b1; end
      rst_n = 1'b1;
      repeat (3) begin @(posedge clk); #1; if ({bus.rvalid, bus.wready} !== 2'b00) bad = 1'b1; end
      checks++; if (bad !== 1'b0) begin failures++; $display("FAIL midrst_no_resp: got %b expected 0", bad); end
      checks++; if ({timer_irq, bus.rdata} !== 33'h0) begin failures++; $display("FAIL midrst_irq_rdata: got irq=%b rdata=%h expected 0,00000000", timer_irq, bus.rdata); end
      do_read(A_CLO, d, v);
      checks++; if (d !== 32'hFFFF_FFFF) begin failures++; $display("FAIL midrst_cmp_lo: got %h expected ffffffff", d); end
      do_read(A_CHI, d, v);
      checks++; if (d !== 32'hFFFF_FFFF) begin failures++; $display("FAIL midrst_cmp_hi: got %h expected ffffffff", d); end
      do_read(A_CTRL, d, v);
      checks++; if (d !== 32'h3) begin failures++; $display("FAIL midrst_ctrl: got %h expected 00000003", d); end
      do_read(A_PRESC, d, v);
      checks++; if (d !== 32'h0) begin failures++; $display("FAIL midrst_presc: got %h expected 00000000", d); end
      do_read(A_HI, d, v);   // shadow was 1 before reset
      checks++; if (d !== 32'h0) begin failures++; $display("FAIL midrst_shadow: got %h expected 00000000", d); end
      do_read(A_LO, d, v);   // accepted at edge 14 after release
      checks++; if (d !== 32'd13) begin failures++; $display("FAIL midrst_mtime: got %0d expected 13", d); end
   endtask

   initial begin
      rst_n = 1'b0;
      bus_idle();
      @(posedge clk); #1;
      test_reset();
      test_default_count();
      test_irq();
      test_coherent();
      test_prescale();
      test_freeze();
      test_strobes_unmapped();
      test_simultaneous();
      test_back_to_back();
      test_reset_midop();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/rv32_mtimer.md
RV32_MTIMER -- requirements
Module: rv32_mtimer

Interface
REQ-001 SHALL have parameter PRESC_WIDTH, default 16, width of the prescaler register.
REQ-002 SHALL have parameter RESET_MTIMECMP, default 64'hFFFF_FFFF_FFFF_FFFF, the reset value of mtimecmp.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, the reset; synchronous, active-low.
REQ-005 SHALL have port sel, input, 1, decoded chip select from the data-bus address decoder.
REQ-006 SHALL have port rready, input, 1, read request from the core LSU.
REQ-007 SHALL have port rvalid, output, 1, read data valid pulse.
REQ-008 SHALL have port wvalid, input, 1, write request from the core LSU.
REQ-009 SHALL have port wready, output, 1, write accepted/complete pulse.
REQ-010 SHALL have port strb, input, 4, byte write strobes.
REQ-011 SHALL have port addr, input, 32, byte address; only addr[4:2] is decoded.
REQ-012 SHALL have port wdata, input, 32, write data.
REQ-013 SHALL have port rdata, output, 32, read data.
REQ-014 SHALL have port timer_irq, output, 1, machine timer interrupt to the core.

Function
REQ-015 SHALL map registers by addr[4:2]: 0 mtime_lo, 1 mtime_hi, 2 mtimecmp_lo, 3 mtimecmp_hi, 4 ctrl (bit0 cnt_en, bit1 irq_en, other bits read 0), 5 presc (PRESC_WIDTH bits, zero-extended); 6-7 unmapped.
REQ-016 SHALL accept a write when sel && wvalid && !resp_busy, and update the addressed register per byte lane where strb[i]=1 in that same cycle.
REQ-017 SHALL accept a read when sel && rready && !wvalid && !resp_busy; write wins when both are requested.
REQ-018 SHALL assert wready (write) or rvalid (read) for exactly one cycle, the cycle after acceptance; resp_busy is high in that cycle, so no request is accepted then.
REQ-019 SHALL hold rdata stable from the rvalid cycle until the next accepted read.
REQ-020 SHALL ignore writes to unmapped offsets, return 0 for reads of them, and still complete the handshake.
REQ-021 SHALL run a prescale counter while cnt_en=1; when it equals presc it resets to 0 and issues a tick, so mtime advances once every presc+1 cycles.
REQ-022 SHALL increment the 64-bit mtime by 1 on each tick, wrapping from all-ones to 0.
REQ-023 SHALL give a software write to mtime_lo or mtime_hi priority over the increment in the same cycle, with no increment applied to the written value.
REQ-024 SHALL freeze both mtime and the prescale counter while cnt_en=0.
REQ-025 SHALL clear the prescale counter on any write to presc.
REQ-026 SHALL, on a read of mtime_lo, latch the current mtime[63:32] into a shadow register.
REQ-027 SHALL return the shadow register for reads of mtime_hi, giving a coherent 64-bit lo-then-hi read.
REQ-028 SHALL drive timer_irq as a registered (mtime >= mtimecmp, unsigned 64-bit) && irq_en, one cycle after the condition holds.
REQ-029 SHALL keep timer_irq level-sensitive; it clears only by raising mtimecmp, clearing irq_en, or writing mtime.
REQ-030 SHALL keep the decode function of sel only; addr bits above [4:2] are ignored.

Reset
REQ-031 SHALL, while rst_n=0 at a clock edge, set: mtime=0, shadow=0, mtimecmp=RESET_MTIMECMP, ctrl=2'b11, presc=0, prescale counter=0, resp_busy=0, rvalid=0, wready=0, rdata=0, timer_irq=0.
REQ-032 SHALL abort an in-flight response on reset, with no rvalid or wready issued after reset release for a request accepted before reset.

Verification
REQ-033 SHALL be verified for default prescale: after reset, idle 10 cycles, then read mtime_lo -> rvalid one cycle after acceptance, rdata=count of enabled cycles (10 +/- handshake offset, checked exactly against a model).
REQ-034 SHALL be verified for the interrupt: write mtimecmp_hi=0 and mtimecmp_lo=20 -> timer_irq rises exactly one cycle after mtime reaches 20; write mtimecmp_lo=0xFFFF_FFFF -> timer_irq falls one cycle later.
REQ-035 SHALL be verified for the coherent read: write mtime_hi=0, mtime_lo=0xFFFF_FFFE, presc=0; read lo then hi across the carry -> the hi value matches the hi at the lo-read instant.
REQ-036 SHALL be verified for strobes and unmapped offsets: write 0xAABBCCDD to presc with strb=4'b0001 -> presc=0x00DD; write/read offset 0x1C -> wready/rvalid still pulse, rdata=0.
REQ-037 SHALL be verified for simultaneous events: assert rready and wvalid together -> only the write is accepted; tick coincident with a mtime_lo write of 5 -> mtime_lo=5.
REQ-038 SHALL be verified for reset mid-operation: assert rst_n=0 in the cycle after a read is accepted -> rvalid stays 0 and all registers take their REQ-031 values.
